// File: rtl/mem_pkg.sv
// Shared size/error codes, FSM state encoding and default memory geometry
// for the load/store access unit.
package mem_pkg;

    localparam int unsigned DM_WORDS_DEF = 3072;
    localparam int unsigned WADDR_W_DEF  = 12;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_ALIGN = 2'b01;
    localparam logic [1:0] ERR_RANGE = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACC   = 2'd1,
        ST_MERGE = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

endpackage

// File: rtl/mem_access_unit_lane.sv
// Byte/halfword lane handling: store-lane merge into an old word and
// load-lane extraction with sign or zero extension.
module mem_lane_ext
    import mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] old_word,
    input  logic [31:0] new_data,
    output logic [31:0] merged_word,
    output logic [31:0] load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Size 11 falls into the default arm and behaves as a full word.
    always_comb begin
        merged_word = old_word;
        load_data   = old_word;
        byte_sel    = old_word[{addr_lo, 3'b000} +: 8];
        half_sel    = old_word[{addr_lo[1], 4'b0000} +: 16];
        case (size)
            SZ_BYTE: begin
                merged_word[{addr_lo, 3'b000} +: 8] = new_data[7:0];
                load_data = sign_ext ? {{24{byte_sel[7]}}, byte_sel}
                                     : {24'b0, byte_sel};
            end
            SZ_HALF: begin
                merged_word[{addr_lo[1], 4'b0000} +: 16] = new_data[15:0];
                load_data = sign_ext ? {{16{half_sel[15]}}, half_sel}
                                     : {16'b0, half_sel};
            end
            default: begin
                merged_word = new_data;
                load_data   = old_word;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit between EX/MEM and a single-port word memory; sub-word
// stores are performed as read-modify-write, bad addresses never reach memory.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int unsigned DM_WORDS = DM_WORDS_DEF,
    parameter int unsigned WADDR_W  = WADDR_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_write,
    input  logic [1:0]         req_size,
    input  logic               req_signed,
    input  logic [31:0]        req_addr,
    input  logic [31:0]        req_wdata,
    input  logic [31:0]        req_pc,
    output logic               rsp_valid,
    output logic [31:0]        rsp_rdata,
    output logic [1:0]         rsp_err,
    output logic               dm_we,
    output logic [WADDR_W-1:0] dm_addr,
    output logic [31:0]        dm_wdata,
    output logic [31:0]        dm_pc,
    output logic [31:0]        dm_full_addr,
    input  logic [31:0]        dm_rdata
);

    localparam logic [31:0] ADDR_LIMIT = 32'(DM_WORDS * 4);

    state_e      state_q, state_d;
    logic        write_q, write_d;
    logic [1:0]  size_q, size_d;
    logic        signed_q, signed_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] merge_q, merge_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic [1:0]  rsp_err_q, rsp_err_d;

    logic        misalign;
    logic        out_range;
    logic [1:0]  req_err;
    logic [31:0] lane_old;
    logic [31:0] lane_merged;
    logic [31:0] lane_load;

    // Alignment is judged before range so a misaligned high address reports 01.
    always_comb begin
        misalign  = ((req_size == SZ_HALF) && req_addr[0]) ||
                    (req_size[1] && (req_addr[1:0] != 2'b00));
        out_range = (req_addr >= ADDR_LIMIT);
        req_err   = misalign ? ERR_ALIGN : (out_range ? ERR_RANGE : ERR_NONE);
    end

    // During MERGE the captured word is the base; otherwise the live read word.
    assign lane_old = (state_q == ST_MERGE) ? merge_q : dm_rdata;

    mem_lane_ext u_lane (
        .size        (size_q),
        .sign_ext    (signed_q),
        .addr_lo     (addr_q[1:0]),
        .old_word    (lane_old),
        .new_data    (wdata_q),
        .merged_word (lane_merged),
        .load_data   (lane_load)
    );

    assign req_ready    = (state_q == ST_IDLE);
    assign dm_we        = !reset && (((state_q == ST_ACC) && write_q && size_q[1]) ||
                                     (state_q == ST_MERGE));
    assign dm_addr      = addr_q[WADDR_W+1:2];
    assign dm_wdata     = lane_merged;
    assign dm_pc        = pc_q;
    assign dm_full_addr = {addr_q[31:2], 2'b00};
    assign rsp_valid    = rsp_valid_q;
    assign rsp_rdata    = rsp_rdata_q;
    assign rsp_err      = rsp_err_q;

    // Response fields only change on the edge that enters RESP, so they hold between responses.
    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        size_d      = size_q;
        signed_d    = signed_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        pc_d        = pc_q;
        merge_d     = merge_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    write_d  = req_write;
                    size_d   = req_size;
                    signed_d = req_signed;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    pc_d     = req_pc;
                    if (req_err != ERR_NONE) begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = 32'h0;
                        rsp_err_d   = req_err;
                    end else begin
                        state_d = ST_ACC;
                    end
                end
            end
            ST_ACC: begin
                if (!write_q) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = lane_load;
                    rsp_err_d   = ERR_NONE;
                end else if (size_q[1]) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = 32'h0;
                    rsp_err_d   = ERR_NONE;
                end else begin
                    state_d = ST_MERGE;
                    merge_d = dm_rdata;
                end
            end
            ST_MERGE: begin
                state_d     = ST_RESP;
                rsp_valid_d = 1'b1;
                rsp_rdata_d = 32'h0;
                rsp_err_d   = ERR_NONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            write_q     <= 1'b0;
            size_q      <= 2'b00;
            signed_q    <= 1'b0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            pc_q        <= 32'h0;
            merge_q     <= 32'h0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= ERR_NONE;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            size_q      <= size_d;
            signed_q    <= signed_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            pc_q        <= pc_d;
            merge_q     <= merge_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed plus randomized bench for mem_access_unit against a byte-array
// memory model with timing and write expectations.
module tb_mem_access_unit;

    localparam int unsigned NW = 3072;
    localparam int unsigned NB = NW * 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata, req_pc;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_err;
    logic        dm_we;
    logic [11:0] dm_addr;
    logic [31:0] dm_wdata, dm_pc, dm_full_addr, dm_rdata;

    logic [7:0]  ref_b [0:NB-1];
    logic [31:0] mem   [0:NW-1];
    logic        mem_load;

    int compared = 0;
    int mism     = 0;

    mem_access_unit dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_pc(req_pc),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_pc(dm_pc),
        .dm_full_addr(dm_full_addr), .dm_rdata(dm_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_word(input int unsigned wi);
        return {ref_b[4*wi+3], ref_b[4*wi+2], ref_b[4*wi+1], ref_b[4*wi]};
    endfunction

    function automatic logic [31:0] ref_load(input int unsigned a, input int nb, input logic sg);
        logic [31:0] v;
        v = 32'h0;
        for (int i = 0; i < nb; i++) v = v | (32'(ref_b[a + i]) << (8 * i));
        if (sg && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
        return v;
    endfunction

    task automatic ref_store(input int unsigned a, input int nb, input logic [31:0] wd);
        for (int i = 0; i < nb; i++) ref_b[a + i] = 8'(wd >> (8 * i));
    endtask

    // Memory image is loaded from the reference once, then only the DUT writes it.
    assign dm_rdata = (dm_addr < 12'(NW)) ? mem[dm_addr] : 32'h0;
    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < NW; i++) mem[i] <= ref_word(i);
        end else if (dm_we && dm_addr < 12'(NW)) begin
            mem[dm_addr] <= dm_wdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mism++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One full request from IDLE; returns at the negedge after the RESP cycle.
    task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd_o);
        int          nb, e_lat, e_wcyc, lat, nwr, wcyc, waited;
        logic [1:0]  e_err, g_err;
        logic [31:0] e_rd, e_word, pc, g_rd, w_data, w_full, w_pc, w_addr;
        nb     = (sz == 2'b00) ? 1 : ((sz == 2'b01) ? 2 : 4);
        e_err  = (a % nb != 0) ? 2'b01 : ((a >= NB) ? 2'b10 : 2'b00);
        e_rd   = 32'h0;
        e_word = 32'h0;
        e_wcyc = 0;
        e_lat  = 1;
        if (e_err == 2'b00) begin
            if (w) begin
                ref_store(int'(a), nb, wd);
                e_word = ref_word(int'(a) / 4);
                e_wcyc = (nb == 4) ? 1 : 2;
                e_lat  = e_wcyc + 1;
            end else begin
                e_rd  = ref_load(int'(a), nb, sg);
                e_lat = 2;
            end
        end
        pc = $urandom;
        req_write = w; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = wd; req_pc = pc; req_valid = 1'b1;
        waited = 0;
        while (!req_ready && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        chk("accept_ready", 32'(req_ready), 32'h1);
        @(negedge clk);
        req_valid = 1'b0;
        chk("busy_ready", 32'(req_ready), 32'h0);
        lat = 0; nwr = 0; wcyc = 0;
        g_rd = 32'hDEAD_BEEF; g_err = 2'b11;
        w_data = 0; w_full = 0; w_pc = 0; w_addr = 0;
        for (int c = 1; c <= 6; c++) begin
            if (dm_we) begin
                nwr++; wcyc = c; w_data = dm_wdata;
                w_addr = 32'(dm_addr); w_full = dm_full_addr; w_pc = dm_pc;
            end
            if (rsp_valid) begin
                lat = c; g_rd = rsp_rdata; g_err = rsp_err;
                break;
            end
            @(negedge clk);
        end
        chk($sformatf("latency a=%h sz=%0d w=%0d", a, sz, w), 32'(lat), 32'(e_lat));
        chk($sformatf("err a=%h", a), 32'(g_err), 32'(e_err));
        chk($sformatf("rdata a=%h sz=%0d sg=%0d", a, sz, sg), g_rd, e_rd);
        chk($sformatf("nwrites a=%h", a), 32'(nwr), (e_wcyc != 0) ? 32'h1 : 32'h0);
        if (e_wcyc != 0) begin
            chk($sformatf("wcycle a=%h", a), 32'(wcyc), 32'(e_wcyc));
            chk($sformatf("wdata a=%h", a), w_data, e_word);
            chk($sformatf("waddr a=%h", a), w_addr, a >> 2);
            chk($sformatf("wfull a=%h", a), w_full, a & 32'hFFFF_FFFC);
            chk($sformatf("wpc a=%h", a), w_pc, pc);
        end
        rd_o = g_rd;
        @(negedge clk);
        chk("rsp_pulse", 32'(rsp_valid), 32'h0);
        chk("rsp_hold", g_rd, rsp_rdata);
    endtask

    initial begin
        logic [31:0] rd, a, w0, w1;
        logic        w, sg;
        logic [1:0]  sz;
        int          nb, acc2, npulse, nwr, r;

        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd, a, w0, w1;
        logic        w, sg;
        logic [1:0]  sz;
        int          nb, acc2, npulse, nwr, r;

        reset = 1'b1; mem_load = 1'b1; req_valid = 1'b0; req_write = 1'b0;
        req_size = 2'b00; req_signed = 1'b0; req_addr = 0; req_wdata = 0; req_pc = 0;
        for (int i = 0; i < NB; i++) ref_b[i] = 8'($urandom);
        @(negedge clk);
        chk("reset_we", 32'(dm_we), 32'h0);
        @(negedge clk);
        mem_load = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        chk("reset_ready", 32'(req_ready), 32'h1);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("reset_rdata", rsp_rdata, 32'h0);
        chk("reset_err", 32'(rsp_err), 32'h0);

        // Word store then load
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h1234_5678, rd);
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd);
        chk("lw_0x10", rd, 32'h1234_5678);

        // Byte store merge
        do_req(1'b1, 2'b10, 1'b0, 32'h20, 32'hAABB_CCDD, rd);
        do_req(1'b1, 2'b00, 1'b0, 32'h22, 32'h0000_00EE, rd);
        chk("sb_merge_word", mem[8], 32'hAAEE_CCDD);

        // Load extension
        do_req(1'b1, 2'b10, 1'b0, 32'h30, 32'h80FF_7F01, rd);
        do_req(1'b0, 2'b00, 1'b1, 32'h33, 32'h0, rd);
        chk("lb_0x33", rd, 32'hFFFF_FF80);
        do_req(1'b0, 2'b00, 1'b0, 32'h33, 32'h0, rd);
        chk("lbu_0x33", rd, 32'h0000_0080);
        do_req(1'b0, 2'b01, 1'b1, 32'h30, 32'h0, rd);
        chk("lh_0x30", rd, 32'h0000_7F01);
        do_req(1'b0, 2'b01, 1'b0, 32'h32, 32'h0, rd);
        chk("lhu_0x32", rd, 32'h0000_80FF);

        // Error cases, reserved size, top-of-memory boundary
        do_req(1'b0, 2'b10, 1'b0, 32'h6, 32'h0, rd);
        do_req(1'b1, 2'b10, 1'b0, 32'h3000, 32'h5555_AAAA, rd);
        do_req(1'b0, 2'b01, 1'b1, 32'h3001, 32'h0, rd);
        do_req(1'b1, 2'b00, 1'b0, 32'h2FFF, 32'h0000_0042, rd);
        do_req(1'b0, 2'b11, 1'b0, 32'h3, 32'h0, rd);
        do_req(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, rd);
        chk("lw_size11", rd, 32'h1234_5678);

        // Reset during MERGE of a halfword store
        req_write = 1'b1; req_size = 2'b01; req_signed = 1'b0;
        req_addr = 32'h40; req_wdata = 32'h0000_BEEF; req_pc = 32'h100; req_valid = 1'b1;
        chk("rst_start_ready", 32'(req_ready), 32'h1);
        @(negedge clk);
        req_valid = 1'b0;
        chk("rst_acc_we", 32'(dm_we), 32'h0);
        @(negedge clk);
        chk("rst_merge_we_pre", 32'(dm_we), 32'h1);
        reset = 1'b1;
        #1;
        chk("rst_merge_we", 32'(dm_we), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_after_ready", 32'(req_ready), 32'h1);
        chk("rst_after_valid", 32'(rsp_valid), 32'h0);
        chk("rst_after_rdata", rsp_rdata, 32'h0);
        npulse = 0;
        for (int c = 0; c < 3; c++) begin
            if (rsp_valid) npulse++;
            @(negedge clk);
        end
        chk("rst_no_rsp", 32'(npulse), 32'h0);
        chk("rst_mem_intact", mem[16], ref_word(16));

        // Busy hold: req_valid held across two stores
        req_write = 1'b1; req_size = 2'b10; req_signed = 1'b0;
        req_addr = 32'h50; req_wdata = 32'h1111_2222; req_pc = 32'h200; req_valid = 1'b1;
        chk("busy_start_ready", 32'(req_ready), 32'h1);
        @(negedge clk);
        req_size = 2'b00; req_addr = 32'h51; req_wdata = 32'hABCD_EF33; req_pc = 32'h204;
        acc2 = 0; npulse = 0; nwr = 0; w0 = 0; w1 = 0;
        for (int c = 1; c <= 8; c++) begin
            if (acc2 != 0 && c == acc2 + 1) req_valid = 1'b0;
            if (rsp_valid) npulse++;
            if (dm_we) begin
                if (nwr == 0) w0 = dm_wdata; else w1 = dm_wdata;
                nwr++;
            end
            if (req_ready && acc2 == 0) acc2 = c;
            @(negedge clk);
        end
        req_valid = 1'b0;
        chk("busy_accept2_cycle", 32'(acc2), 32'h3);
        chk("busy_pulses", 32'(npulse), 32'h2);
        chk("busy_writes", 32'(nwr), 32'h2);
        chk("busy_w0", w0, 32'h1111_2222);
        chk("busy_w1", w1, 32'h1111_3322);
        ref_store(32'h50, 4, 32'h1111_2222);
        ref_store(32'h51, 1, 32'hABCD_EF33);
        do_req(1'b0, 2'b10, 1'b0, 32'h50, 32'h0, rd);
        chk("busy_readback", rd, 32'h1111_3322);

        // Randomized mix biased toward a small region and the range boundary
        for (int k = 0; k < 150; k++) begin
            w  = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            sg = 1'($urandom_range(0, 1));
            nb = (sz == 2'b00) ? 1 : ((sz == 2'b01) ? 2 : 4);
            r  = $urandom_range(0, 9);
            if (r < 6)       a = 32'($urandom_range(0, 127));
            else if (r < 8)  a = 32'(NB - 64) + 32'($urandom_range(0, 63));
            else if (r == 8) a = 32'(NB) + 32'($urandom_range(0, 8191));
            else             a = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & ~32'(nb - 1);
            do_req(w, sz, sg, a, $urandom, rd);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
        $finish;
    end

endmodule
